// File: rtl/mem_port_arbiter.sv
// Multiplexes NCH cache-side requesters onto one shared memory port using
// fixed or round-robin priority, with a completion watchdog and per-channel error pulse.
module mem_port_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NCH-1:0]      ch_rw_flag,
  input  logic [AW*NCH-1:0]     ch_addr,
  input  logic [DW*NCH-1:0]     ch_wdata,
  input  logic [(DW/8)*NCH-1:0] ch_mask,
  output logic [DW-1:0]         ch_rdata,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_done,
  output logic [NCH-1:0]        ch_err,
  output logic [1:0]            mem_rw_flag,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_write_data,
  output logic [DW/8-1:0]       mem_write_mask,
  input  logic [DW-1:0]         mem_read_data,
  input  logic                  mem_busy,
  input  logic                  mem_done
);

  localparam int MW = DW / 8;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] LAST_RST = GW'(NCH - 1);

  // S_IDLE: arbitrate | S_BUSY: wait for mem_done or watchdog | S_DONE: one-cycle gap
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q, last_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      mem_rw_flag_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [MW-1:0]   mem_mask_q;
  logic [DW-1:0]   ch_rdata_q;
  logic [NCH-1:0]  ch_done_q, ch_err_q;

  logic [1:0]      flag_a  [NCH];
  logic [AW-1:0]   addr_a  [NCH];
  logic [DW-1:0]   wdata_a [NCH];
  logic [MW-1:0]   mask_a  [NCH];
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  grant_oh;
  logic [GW-1:0]   grant_d;
  logic [GW-1:0]   sel_idx;
  logic            grant_vld;

  assign grant_oh = {{(NCH-1){1'b0}}, 1'b1} << grant_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign flag_a[i]  = ch_rw_flag[2*i +: 2];
    assign addr_a[i]  = ch_addr[AW*i +: AW];
    assign wdata_a[i] = ch_wdata[DW*i +: DW];
    assign mask_a[i]  = ch_mask[MW*i +: MW];
    assign req[i]     = |flag_a[i];
    assign ch_busy[i] = mem_busy
                      | ((state_q != S_IDLE) & ~grant_oh[i])
                      | ((state_q == S_BUSY) &  grant_oh[i]);
  end

  // Round-robin scans starting just after the previous winner.
  always_comb begin
    grant_d   = '0;
    grant_vld = 1'b0;
    sel_idx   = '0;
    for (int off = 0; off < NCH; off++) begin
      sel_idx = (RR != 0) ? GW'((int'(last_q) + 1 + off) % NCH) : GW'(off);
      if (!grant_vld && req[sel_idx]) begin
        grant_vld = 1'b1;
        grant_d   = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      last_q        <= LAST_RST;
      cnt_q         <= '0;
      mem_rw_flag_q <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_mask_q    <= '0;
      ch_rdata_q    <= '0;
      ch_done_q     <= '0;
      ch_err_q      <= '0;
    end else begin
      ch_done_q <= '0;
      ch_err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (!mem_busy && grant_vld) begin
            state_q       <= S_BUSY;
            grant_q       <= grant_d;
            last_q        <= grant_d;
            cnt_q         <= '0;
            mem_rw_flag_q <= flag_a[grant_d][1] ? 2'b10 : 2'b01;
            mem_addr_q    <= addr_a[grant_d];
            mem_wdata_q   <= wdata_a[grant_d];
            mem_mask_q    <= mask_a[grant_d];
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            ch_rdata_q    <= mem_read_data;
            ch_done_q     <= grant_oh;
            mem_rw_flag_q <= '0;
            state_q       <= S_DONE;
          end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            ch_done_q     <= grant_oh;
            ch_err_q      <= grant_oh;
            mem_rw_flag_q <= '0;
            state_q       <= S_DONE;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_rdata       = ch_rdata_q;
  assign ch_done        = ch_done_q;
  assign ch_err         = ch_err_q;
  assign mem_rw_flag    = mem_rw_flag_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write_mask = mem_mask_q;

endmodule
